// File: rtl/display_scanner.sv
// Time-multiplexed scanner for a common-bus 7-segment display; new values swap in only at frame boundaries.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses digit enables for leading-zero digits.
module display_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] value,
  input  logic                value_valid,
  output logic                value_ready,
  output logic [3:0]          bcd,
  output logic [DIGITS-1:0]   dig_en,
  output logic                frame_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_disp;
  logic [4*DIGITS-1:0] r_pend;
  logic                r_pend_full;
  logic [3:0]          r_bcd;
  logic [DIGITS-1:0]   r_dig_en;
  logic                r_frame_tick;

  logic                w_cnt_end;
  logic                w_boundary;
  logic                w_blank;
  logic [3:0]          w_nib;
  logic [DIGITS-1:0]   w_onehot;
  logic [DIGITS-1:0]   w_keep;

  assign w_cnt_end  = (r_cnt == CNT_LAST);
  assign w_boundary = w_cnt_end && (r_idx == IDX_LAST);

  generate
    if (BLANK == 0) begin : g_noblank
      assign w_blank = 1'b0;
    end else begin : g_blank
      assign w_blank = (r_cnt < CW'(BLANK));
    end
  endgenerate

  always_comb begin
    w_nib    = 4'd0;
    w_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib       = r_disp[4*i +: 4];
        w_onehot[i] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit stays lit if it or any more significant digit is non-zero; digit 0 always lit.
  always_comb begin
    logic w_any;
    w_any  = 1'b0;
    w_keep = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_any     = w_any | (|r_disp[4*i +: 4]);
      w_keep[i] = w_any | (i == 0);
    end
  end
`else
  assign w_keep = '1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pend_full  <= 1'b0;
      r_bcd        <= 4'd0;
      r_dig_en     <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      if (w_cnt_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      // Accept and swap are mutually exclusive: accept needs an empty pending slot.
      if (value_valid && !r_pend_full) begin
        r_pend      <= value;
        r_pend_full <= 1'b1;
      end else if (w_boundary && r_pend_full) begin
        r_disp      <= r_pend;
        r_pend_full <= 1'b0;
      end

      r_bcd        <= w_nib;
      r_dig_en     <= w_blank ? '0 : (w_onehot & w_keep);
      r_frame_tick <= (r_cnt == '0) && (r_idx == '0);
    end
  end

  assign value_ready = ~r_pend_full;
  assign bcd         = r_bcd;
  assign dig_en      = r_dig_en;
  assign frame_tick  = r_frame_tick;

endmodule

// File: tb/tb_display_scanner.sv
// Directed self-checking bench for display_scanner: main instance (4/8/2) plus a no-blank instance (4/2/0).
module tb_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n, rst_b;
  logic [15:0] value, value_b;
  logic        valid, valid_b;
  logic        ready, ready_b;
  logic [3:0]  bcd, bcd_b;
  logic [3:0]  en, en_b;
  logic        tick, tick_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  display_scanner #(.DIGITS(4), .PRESCALE(8), .BLANK(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .value(value), .value_valid(valid), .value_ready(ready),
    .bcd(bcd), .dig_en(en), .frame_tick(tick)
  );

  display_scanner #(.DIGITS(4), .PRESCALE(2), .BLANK(0)) u_dut_b (
    .clk(clk), .rst_n(rst_b), .value(value_b), .value_valid(valid_b), .value_ready(ready_b),
    .bcd(bcd_b), .dig_en(en_b), .frame_tick(tick_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] keep_mask(input logic [15:0] d);
`ifdef LEADING_ZERO_BLANK_EN
    keep_mask = {|d[15:12], |d[15:8], |d[15:4], 1'b1};
`else
    keep_mask = 4'hF;
`endif
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] d, input int i);
    logic [15:0] t;
    t = d >> (4 * i);
    nib = t[3:0];
  endfunction

  // Expected outputs in output cycle c reflect state cycle c-1.
  task automatic chk_scan(input string tag, input int c, input int pre, input int blank,
                          input logic [15:0] d, input logic [3:0] obs_bcd, input logic [3:0] obs_en);
    int s, cnt, idx;
    logic [3:0] oh;
    s   = c - 1;
    cnt = s % pre;
    idx = (s / pre) % 4;
    oh  = 4'b0001 << idx;
    chk($sformatf("%s bcd c=%0d", tag, c), {28'd0, obs_bcd}, {28'd0, nib(d, idx)});
    chk($sformatf("%s en c=%0d", tag, c), {28'd0, obs_en},
        (cnt < blank) ? 32'd0 : {28'd0, oh & keep_mask(d)});
  endtask

  function automatic logic [15:0] main_disp(input int c);
    case ((c - 1) / 32)
      0:       main_disp = 16'h0000;
      1:       main_disp = 16'h1234;
      2:       main_disp = 16'h1111;
      default: main_disp = 16'hABCD;
    endcase
  endfunction

  function automatic logic main_ready(input int c);
    main_ready = (c == 32) || (c == 64) || (c >= 96 && c <= 160);
  endfunction

  initial begin
    rst_n = 1'b0; rst_b = 1'b0;
    value = 16'h0; valid = 1'b0;
    value_b = 16'h0; valid_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst ready", {31'd0, ready}, 32'd1);
    chk("rst bcd", {28'd0, bcd}, 32'd0);
    chk("rst en", {28'd0, en}, 32'd0);
    chk("rst tick", {31'd0, tick}, 32'd0);
    rst_n = 1'b1; value = 16'h1234; valid = 1'b1;

    for (int c = 1; c <= 180; c++) begin
      @(negedge clk);
      chk($sformatf("ready c=%0d", c), {31'd0, ready}, {31'd0, main_ready(c)});
      chk_scan("main", c, 8, 2, main_disp(c), bcd, en);
      if (c >= 2)
        chk($sformatf("tick c=%0d", c), {31'd0, tick}, {31'd0, ((c - 1) % 32) == 0});
      case (c)
        1:       valid = 1'b0;
        32:      begin value = 16'h1111; valid = 1'b1; end
        33:      value = 16'hABCD;
        65:      valid = 1'b0;
        160:     begin value = 16'h5678; valid = 1'b1; end
        161:     valid = 1'b0;
        180:     rst_n = 1'b0;
        default: ;
      endcase
    end

    @(negedge clk);
    chk("midrst ready", {31'd0, ready}, 32'd1);
    chk("midrst bcd", {28'd0, bcd}, 32'd0);
    chk("midrst en", {28'd0, en}, 32'd0);
    chk("midrst tick", {31'd0, tick}, 32'd0);
    rst_n = 1'b1;

    for (int c = 1; c <= 96; c++) begin
      @(negedge clk);
      chk($sformatf("post ready c=%0d", c), {31'd0, ready}, {31'd0, !(c >= 34 && c <= 63)});
      chk_scan("post", c, 8, 2, (c >= 65) ? 16'h0050 : 16'h0000, bcd, en);
      if (c >= 2)
        chk($sformatf("post tick c=%0d", c), {31'd0, tick}, {31'd0, ((c - 1) % 32) == 0});
      if (c == 33) begin value = 16'h0050; valid = 1'b1; end
      if (c == 34) valid = 1'b0;
    end

    chk("b rst en", {28'd0, en_b}, 32'd0);
    chk("b rst ready", {31'd0, ready_b}, 32'd1);
    rst_b = 1'b1; value_b = 16'hF00F; valid_b = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) valid_b = 1'b0;
      chk($sformatf("b ready c=%0d", c), {31'd0, ready_b}, {31'd0, c >= 8});
      chk_scan("b", c, 2, 0, (c >= 9) ? 16'hF00F : 16'h0000, bcd_b, en_b);
      if (c >= 2)
        chk($sformatf("b tick c=%0d", c), {31'd0, tick_b}, {31'd0, ((c - 1) % 8) == 0});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Time-multiplexed driver for a DIGITS-digit common-bus 7-segment display.
- Sits directly upstream of the BCD-to-segment decoder:
  - drives the decoder's 4-bit nibble input with one digit at a time;
  - drives one-hot digit-enable lines in step with that nibble.
- Accepts new display values over a valid/ready handshake and swaps them in only at frame boundaries, so a frame never mixes old and new digits.
- Inserts a blanking gap at the start of every digit slot to suppress ghosting.

Parameters:
- DIGITS, 4: number of display digits; must be >= 1.
- PRESCALE, 1000: clock cycles per digit slot; must be >= 2.
- BLANK, 16: cycles at the start of each slot with all digit enables low; must satisfy 0 <= BLANK < PRESCALE.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- value  input  4*DIGITS  packed nibbles; value[3:0] is digit 0, the least significant.
- value_valid  input  1  value is presented this cycle.
- value_ready  output  1  block can accept value this cycle.
- bcd  output  4  nibble for the segment decoder.
- dig_en  output  DIGITS  one-hot active-high digit enable; all zero during blanking.
- frame_tick  output  1  one-cycle pulse at the start of each frame.

Behaviour:
- Clock and reset:
  - One clock (clk); reset is synchronous and active-low (rst_n).
  - rst_n low at a rising edge clears all state, mid-frame or not: cnt=0, idx=0, disp=0, pend_full=0.
  - Any pending value is discarded on reset.
- Outputs after reset: value_ready=1, bcd=0, dig_en=0, frame_tick=0.
- State:
  - cnt: slot counter, 0..PRESCALE-1.
  - idx: digit index, 0..DIGITS-1.
  - disp: displayed register, 4*DIGITS bits.
  - pending: register, 4*DIGITS bits.
  - pend_full: 1 bit.
- Counting:
  - Each cycle, cnt increments.
  - At cnt==PRESCALE-1: cnt wraps to 0 and idx advances.
  - idx wraps from DIGITS-1 to 0.
  - Frame boundary = the cycle with cnt==PRESCALE-1 and idx==DIGITS-1.
- Handshake:
  - value_ready = !pend_full (registered; equals the pend_full state).
  - Transfer occurs on a cycle with value_valid && value_ready. Then pending <= value and pend_full <= 1.
  - value is ignored when value_ready is 0; the source must hold it.
- Swap:
  - At the frame boundary, if pend_full: disp <= pending and pend_full <= 0.
  - No bypass: a value accepted on the boundary cycle itself is not swapped until the next boundary.
  - Accept and swap cannot both occur on one edge, because accept requires pend_full==0.
- Outputs are registered with 1-cycle latency relative to (cnt, idx, disp):
  - bcd = disp[4*idx +: 4], held through the whole slot, including blanking.
  - dig_en = 0 when cnt < BLANK, else one-hot(idx).
  - frame_tick = 1 for exactly one cycle, in the cycle after idx wraps to 0.
- Arithmetic:
  - cnt width = clog2(PRESCALE).
  - idx width = max(1, clog2(DIGITS)).
  - No other arithmetic.
- DIGITS=1: idx stays 0, and every slot end is a frame boundary.
- BLANK=0: dig_en is never blanked except in the first output cycle after reset.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - digit i > 0 has dig_en held 0 for its entire slot if nibbles i..DIGITS-1 of disp are all zero;
  - digit 0 is always enabled outside blanking;
  - bcd is still driven normally.
- Undefined: all digits are enabled as described above.

Test Plan:
Bench parameters: DIGITS=4, PRESCALE=8, BLANK=2 (slot 8 cycles, frame 32 cycles).
- Reset, then value=16'h1234 with valid for 1 cycle -> value_ready falls next cycle and stays low until the first frame boundary (cycle 31 after reset). Next frame:
  - slot 0: bcd=4, dig_en=0000 for 2 cycles, then 0001 for 6;
  - slots 1..3: bcd=3/2/1 with dig_en=0010/0100/1000;
  - value_ready returns to 1.
- Hold valid with value=16'hABCD while value_ready=0, after a prior load of 16'h1111 -> 16'hABCD is accepted only on the cycle value_ready rises, and is displayed one frame after 16'h1111.
- Run 3 frames -> frame_tick pulses every 32 cycles, exactly 1 cycle wide, each coinciding with bcd switching to digit 0.
- Assert rst_n=0 for 1 cycle mid-slot 2 while pend_full=1 -> next cycle: dig_en=0, bcd=0, value_ready=1, frame_tick=0. Scan restarts at digit 0 and the pending value is never displayed.
- LEADING_ZERO_BLANK_EN defined, value=16'h0050 ->
  - dig_en slots show 0001, 0010, 0000, 0000;
  - bcd shows 0, 5, 0, 0;
  - with the macro undefined, all four digits are enabled.
- BLANK=0, PRESCALE=2, value=16'hF00F -> dig_en cycles 0001, 0010, 0100, 1000 every 2 cycles with no gaps; bcd shows F, 0, 0, F.
